// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI transaction arbiter.
// Holds the FSM state encoding and the counter/index width derivations.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    // One counter serves CS setup, CS hold and the inter-transaction gap.
    function automatic int cnt_width(input int cs_delay, input int gap);
        int m;
        m = (cs_delay > gap) ? cs_delay : gap;
        return $clog2(m) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set request at or above
// i_ptr, wrapping to index 0. The pointer register lives in the parent.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_valid
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        // Wrapped search below the pointer only if nothing was found above it.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer of multi-byte SPI transactions onto one byte-level
// SPI engine, owning a chip select per requester with setup/hold/gap timing.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LEN_W    = 8,
    parameter int CS_DELAY = 4,
    parameter int GAP      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     tx_data,
    output logic [NUM_REQ-1:0]       tx_ack,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       cs_n,
    output logic                     spi_start,
    output logic [7:0]               spi_data_in,
    input  logic                     spi_busy,
    input  logic                     spi_new_data,
    input  logic [7:0]               spi_data_out
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(CS_DELAY, GAP);
    // The state that follows SETUP/HOLD supplies the last delay cycle itself.
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((CS_DELAY > 1) ? CS_DELAY - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    state_e             r_state,       w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
    logic [LEN_W-1:0]   r_rem,         w_rem_nxt;
    logic [IDX_W-1:0]   r_ptr,         w_ptr_nxt;
    logic [NUM_REQ-1:0] r_grant,       w_grant_nxt;
    logic [NUM_REQ-1:0] r_cs_n,        w_cs_n_nxt;
    logic [NUM_REQ-1:0] r_tx_ack,      w_tx_ack_nxt;
    logic [NUM_REQ-1:0] r_rx_valid,    w_rx_valid_nxt;
    logic [NUM_REQ-1:0] r_done,        w_done_nxt;
    logic               r_spi_start,   w_spi_start_nxt;
    logic [7:0]         r_spi_data_in, w_spi_data_in_nxt;
    logic [7:0]         r_rx_data,     w_rx_data_nxt;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic               w_arb_valid;
    logic [LEN_W-1:0]   w_win_len;
    logic [IDX_W-1:0]   w_win_ptr;
    logic [7:0]         w_cur_tx;
    logic               w_finish;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    // Slice selection by one-hot vectors: arbiter winner in IDLE, owner afterwards.
    always_comb begin
        w_win_len = '0;
        w_win_ptr = '0;
        w_cur_tx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_len = req_len[i*LEN_W +: LEN_W];
                w_win_ptr = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
            end
            if (r_grant[i]) begin
                w_cur_tx = tx_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_rem_nxt         = r_rem;
        w_ptr_nxt         = r_ptr;
        w_grant_nxt       = r_grant;
        w_cs_n_nxt        = r_cs_n;
        w_tx_ack_nxt      = '0;
        w_rx_valid_nxt    = '0;
        w_done_nxt        = '0;
        w_spi_start_nxt   = 1'b0;
        w_spi_data_in_nxt = r_spi_data_in;
        w_rx_data_nxt     = r_rx_data;
        w_finish          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_nxt = w_arb_gnt;
                    w_ptr_nxt   = w_win_ptr;
                    w_rem_nxt   = w_win_len;
                    w_cnt_nxt   = '0;
                    if (w_win_len == '0) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_cs_n_nxt  = ~w_arb_gnt;
                        w_state_nxt = (CS_DELAY == 1) ? ST_START : ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == DELAY_LAST) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_START: begin
                if (!spi_busy) begin
                    w_spi_start_nxt   = 1'b1;
                    w_spi_data_in_nxt = w_cur_tx;
                    w_tx_ack_nxt      = r_grant;
                    w_state_nxt       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_new_data) begin
                    w_rx_data_nxt  = spi_data_out;
                    w_rx_valid_nxt = r_grant;
                    w_rem_nxt      = r_rem - 1'b1;
                    // Exit test on the pre-decrement count keeps r_rem from wrapping.
                    if (r_rem == LEN_W'(1)) begin
                        if (CS_DELAY == 1) begin
                            w_finish = 1'b1;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_state_nxt = ST_START;
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == DELAY_LAST) begin
                    w_finish = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                // A still-set grant here means a zero-length request: retire it first.
                if (r_grant != '0) begin
                    w_done_nxt  = r_grant;
                    w_grant_nxt = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_finish) begin
            w_cs_n_nxt  = '1;
            w_done_nxt  = r_grant;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_GAP;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_cs_n        <= '1;
            r_tx_ack      <= '0;
            r_rx_valid    <= '0;
            r_done        <= '0;
            r_spi_start   <= 1'b0;
            r_spi_data_in <= '0;
            r_rx_data     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rem         <= w_rem_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_cs_n        <= w_cs_n_nxt;
            r_tx_ack      <= w_tx_ack_nxt;
            r_rx_valid    <= w_rx_valid_nxt;
            r_done        <= w_done_nxt;
            r_spi_start   <= w_spi_start_nxt;
            r_spi_data_in <= w_spi_data_in_nxt;
            r_rx_data     <= w_rx_data_nxt;
        end
    end

    assign grant       = r_grant;
    assign cs_n        = r_cs_n;
    assign tx_ack      = r_tx_ack;
    assign rx_valid    = r_rx_valid;
    assign done        = r_done;
    assign rx_data     = r_rx_data;
    assign spi_start   = r_spi_start;
    assign spi_data_in = r_spi_data_in;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a loopback byte-engine model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int LEN_W    = 8;
    localparam int CS_DELAY = 4;
    localparam int GAP      = 2;
    localparam int ENG_LAT  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*8-1:0]     tx_data;
    logic [NUM_REQ-1:0]       tx_ack;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       rx_valid;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       cs_n;
    logic                     spi_start;
    logic [7:0]               spi_data_in;
    logic                     spi_busy;
    logic                     spi_new_data;
    logic [7:0]               spi_data_out;

    logic       force_busy;
    logic       eng_busy;
    logic       eng_nd;
    logic [7:0] eng_q;
    logic [7:0] eng_out;
    int         eng_cnt;

    int n_pass = 0;
    int n_total = 0;
    int cs_overlap = 0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LEN_W    (LEN_W),
        .CS_DELAY (CS_DELAY),
        .GAP      (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_len      (req_len),
        .tx_data      (tx_data),
        .tx_ack       (tx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .done         (done),
        .grant        (grant),
        .cs_n         (cs_n),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data),
        .spi_data_out (spi_data_out)
    );

    // Loopback engine: busy for ENG_LAT cycles after start, then new_data with busy low.
    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_nd   <= 1'b0;
            eng_cnt  <= 0;
            eng_q    <= 8'h00;
            eng_out  <= 8'h00;
        end else begin
            eng_nd <= 1'b0;
            if (spi_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= ENG_LAT;
                eng_q    <= spi_data_in;
            end else if (eng_busy) begin
                if (eng_cnt == 1) begin
                    eng_busy <= 1'b0;
                    eng_nd   <= 1'b1;
                    eng_out  <= eng_q;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    assign spi_busy     = eng_busy | force_busy;
    assign spi_new_data = eng_nd;
    assign spi_data_out = eng_out;

    always @(negedge clk) begin
        if (!rst && ($countones(~cs_n) > 1)) cs_overlap++;
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        req_len = '0;
        tx_data = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
        n_total++;
        if (cs_n !== 2'b11) $display("FAIL reset_cs_n: got %b want 11", cs_n); else n_pass++;
        n_total++;
        if ({tx_ack, rx_valid, done} !== 6'b0) $display("FAIL reset_pulses: got %b want 0", {tx_ack, rx_valid, done}); else n_pass++;
        n_total++;
        if ({spi_start, spi_data_in, rx_data} !== 17'b0) $display("FAIL reset_data: got %h want 0", {spi_start, spi_data_in, rx_data}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] bytes [3] = '{8'hA5, 8'h3C, 8'hFF};
        logic [7:0] rx [3] = '{8'h00, 8'h00, 8'h00};
        int cs_fall = -1, cs_rise = -1, first_start = -1, last_nd = -1, done_c = -1;
        int n_ack = 0, n_rx = 0, n_done = 0, n_start = 0, ti = 0;
        logic prev_cs = 1'b1;
        req_len = '0;
        req_len[7:0] = 8'd3;
        tx_data[7:0] = bytes[0];
        req = 2'b01;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (prev_cs && !cs_n[0]) cs_fall = c;
            if (!prev_cs && cs_n[0]) cs_rise = c;
            prev_cs = cs_n[0];
            if (spi_start) begin
                n_start++;
                if (first_start < 0) first_start = c;
            end
            if (spi_new_data) last_nd = c;
            if (rx_valid[0]) begin
                if (n_rx < 3) rx[n_rx] = rx_data;
                n_rx++;
            end
            if (tx_ack[0]) begin
                n_ack++;
                if (ti < 2) ti++;
                tx_data[7:0] = bytes[ti];
            end
            if (done[0]) begin
                n_done++;
                done_c = c;
                req = 2'b00;
            end
        end
        n_total++;
        if (first_start - cs_fall !== CS_DELAY) $display("FAIL single_setup: got %0d cycles want %0d", first_start - cs_fall, CS_DELAY); else n_pass++;
        n_total++;
        if (n_start !== 3 || n_ack !== 3) $display("FAIL single_starts: got start=%0d ack=%0d want 3/3", n_start, n_ack); else n_pass++;
        n_total++;
        if (n_rx !== 3) $display("FAIL single_rx_count: got %0d want 3", n_rx); else n_pass++;
        n_total++;
        if ({rx[0], rx[1], rx[2]} !== 24'hA53CFF) $display("FAIL single_rx_data: got %h want a53cff", {rx[0], rx[1], rx[2]}); else n_pass++;
        n_total++;
        if (cs_rise - last_nd !== CS_DELAY) $display("FAIL single_hold: got %0d cycles want %0d", cs_rise - last_nd, CS_DELAY); else n_pass++;
        n_total++;
        if (n_done !== 1 || done_c !== cs_rise) $display("FAIL single_done: got count=%0d at %0d want 1 at %0d", n_done, done_c, cs_rise); else n_pass++;
        n_total++;
        if (grant !== 2'b00) $display("FAIL single_grant_idle: got %b want 00", grant); else n_pass++;
    endtask

    task automatic test_rr();
        logic [1:0] gseq [8];
        logic [1:0] prev_g = 2'b00;
        logic prev_all = 1'b1;
        logic [7:0] rx0 = 8'h00, rx1 = 8'h00;
        int n_g = 0, n_done = 0, rise = -1, gap_first = -1;
        do_reset();
        cs_overlap = 0;
        req_len = {8'd1, 8'd1};
        tx_data = {8'h22, 8'h11};
        req = 2'b11;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (prev_g == 2'b00 && grant != 2'b00 && n_g < 8) begin
                gseq[n_g] = grant;
                n_g++;
            end
            prev_g = grant;
            if (!prev_all && (&cs_n)) rise = c;
            if (prev_all && !(&cs_n) && rise >= 0 && gap_first < 0) gap_first = c - rise;
            prev_all = &cs_n;
            if (rx_valid[0]) rx0 = rx_data;
            if (rx_valid[1]) rx1 = rx_data;
            if (done != 2'b00) begin
                n_done++;
                if (n_done == 8) req = 2'b00;
            end
        end
        n_total++;
        if (n_g !== 8) $display("FAIL rr_grant_count: got %0d want 8", n_g); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k < n_g) begin
                n_total++;
                if (gseq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL rr_order[%0d]: got %b want %b", k, gseq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
            end
        end
        n_total++;
        if (gap_first !== GAP + 1) $display("FAIL rr_gap: got %0d all-high cycles want %0d", gap_first, GAP + 1); else n_pass++;
        n_total++;
        if (cs_overlap !== 0) $display("FAIL rr_cs_overlap: got %0d cycles want 0", cs_overlap); else n_pass++;
        n_total++;
        if (n_done !== 8) $display("FAIL rr_done_count: got %0d want 8", n_done); else n_pass++;
        n_total++;
        if ({rx0, rx1} !== 16'h1122) $display("FAIL rr_rx_route: got %h want 1122", {rx0, rx1}); else n_pass++;
    endtask

    task automatic test_len0();
        logic [1:0] prev_g = 2'b00;
        int g_c = -1, done_c = -1, n_done = 0, n_start = 0, cs_low = 0;
        req_len[15:8] = 8'd0;
        req = 2'b10;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (prev_g == 2'b00 && grant == 2'b10 && g_c < 0) g_c = c;
            prev_g = grant;
            if (spi_start) n_start++;
            if (cs_n !== 2'b11) cs_low++;
            if (done[1]) begin
                n_done++;
                done_c = c;
                req = 2'b00;
            end
        end
        n_total++;
        if (g_c < 0 || done_c - g_c !== 1) $display("FAIL len0_done_latency: got grant@%0d done@%0d want 1 apart", g_c, done_c); else n_pass++;
        n_total++;
        if (n_done !== 1) $display("FAIL len0_done_count: got %0d want 1", n_done); else n_pass++;
        n_total++;
        if (n_start !== 0 || cs_low !== 0) $display("FAIL len0_no_bus: got start=%0d cs_low=%0d want 0/0", n_start, cs_low); else n_pass++;
    endtask

    task automatic test_busy();
        int c0 = -1, rel = -1, first_start = -1, n_start = 0, n_done = 0;
        logic [7:0] rx_b = 8'h00;
        logic prev_cs = 1'b1;
        force_busy = 1'b1;
        req_len[7:0] = 8'd1;
        tx_data[7:0] = 8'h5A;
        req = 2'b01;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (prev_cs && !cs_n[0]) c0 = c;
            prev_cs = cs_n[0];
            if (spi_start) begin
                n_start++;
                if (first_start < 0) first_start = c;
            end
            if (rx_valid[0]) rx_b = rx_data;
            if (done[0]) begin
                n_done++;
                req = 2'b00;
            end
            if (c0 >= 0 && c == c0 + CS_DELAY + 10) begin
                force_busy = 1'b0;
                rel = c;
            end
        end
        force_busy = 1'b0;
        n_total++;
        if (rel < 0 || first_start !== rel + 1) $display("FAIL busy_start_time: got %0d want %0d", first_start, rel + 1); else n_pass++;
        n_total++;
        if (n_start !== 1) $display("FAIL busy_start_count: got %0d want 1", n_start); else n_pass++;
        n_total++;
        if (n_done !== 1 || rx_b !== 8'h5A) $display("FAIL busy_complete: got done=%0d rx=%h want 1/5a", n_done, rx_b); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_ack = 0, n_done = 0, n_done2 = 0;
        logic saw2 = 1'b0;
        logic [1:0] prev_g = 2'b00, g_first = 2'b00;
        logic g_seen = 1'b0;
        req_len[7:0] = 8'd4;
        tx_data[7:0] = 8'h10;
        req = 2'b01;
        for (int c = 0; c < 200 && !saw2; c++) begin
            @(negedge clk);
            if (tx_ack[0]) begin
                n_ack++;
                tx_data[7:0] = tx_data[7:0] + 8'h10;
                if (n_ack == 2) saw2 = 1'b1;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (!saw2) $display("FAIL rstmid_reached_byte2: got %0d acks want 2", n_ack); else n_pass++;
        n_total++;
        if (cs_n !== 2'b11 || grant !== 2'b00) $display("FAIL rstmid_release: got cs_n=%b grant=%b want 11/00", cs_n, grant); else n_pass++;
        rst = 1'b0;
        req = 2'b00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done != 2'b00) n_done++;
        end
        n_total++;
        if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d want 0", n_done); else n_pass++;
        req_len = {8'd1, 8'd1};
        req = 2'b11;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (prev_g == 2'b00 && grant != 2'b00 && !g_seen) begin
                g_first = grant;
                g_seen = 1'b1;
            end
            prev_g = grant;
            if (done != 2'b00) begin
                n_done2++;
                req = 2'b00;
            end
        end
        n_total++;
        if (g_first !== 2'b01) $display("FAIL rstmid_ptr_zero: got %b want 01", g_first); else n_pass++;
        n_total++;
        if (n_done2 !== 1) $display("FAIL rstmid_after_done: got %0d want 1", n_done2); else n_pass++;
    endtask

    task automatic test_len255();
        int n_rx = 0, n_start = 0, n_ack = 0, n_done = 0, rx_err = 0, late_start = 0, tail = -1;
        logic [7:0] exp_rx = 8'h00;
        req_len[7:0] = 8'd255;
        tx_data[7:0] = 8'h00;
        req = 2'b01;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (spi_start) begin
                n_start++;
                if (n_done > 0) late_start++;
            end
            if (tx_ack[0]) begin
                n_ack++;
                tx_data[7:0] = tx_data[7:0] + 8'h01;
            end
            if (rx_valid[0]) begin
                if (rx_data !== exp_rx) rx_err++;
                exp_rx = exp_rx + 8'h01;
                n_rx++;
            end
            if (done[0]) begin
                n_done++;
                req = 2'b00;
                tail = 30;
            end
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        n_total++;
        if (n_rx !== 255) $display("FAIL len255_rx_count: got %0d want 255", n_rx); else n_pass++;
        n_total++;
        if (n_start !== 255 || n_ack !== 255) $display("FAIL len255_starts: got start=%0d ack=%0d want 255/255", n_start, n_ack); else n_pass++;
        n_total++;
        if (rx_err !== 0) $display("FAIL len255_rx_data: got %0d wrong bytes want 0", rx_err); else n_pass++;
        n_total++;
        if (n_done !== 1 || late_start !== 0) $display("FAIL len255_end: got done=%0d late_start=%0d want 1/0", n_done, late_start); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_len = '0;
        tx_data = '0;
        force_busy = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_len0();
        test_busy();
        test_reset_mid();
        test_len255();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
